fifo_rd_ptr_empty: RTL and testbench

Read-domain pointer and empty-flag generator for the team's asynchronous FIFO. It consumes the write pointer (Gray code) after it has crossed into the read clock domain through the two-flop pointer synchronizer. It keeps the read pointer in binary and Gray form, and drives the RAM read address. It raises `empty`, an optional `almost_empty`, and a sticky `underflow` flag. Its Gray read pointer is the value the opposite-direction synchronizer carries into the write domain.

---
 rtl/fifo_rd_ptr_empty_if.sv | 24 ++
 rtl/fifo_rd_ptr_empty.sv | 80 ++++++++
 tb/tb_fifo_rd_ptr_empty.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ptr_empty_if.sv
// Read-side bus of the async FIFO read-pointer block: consumer handshake,
// synchronized write pointer in, RAM address / Gray pointer / status flags out.
interface fifo_rd_ptr_empty_if #(
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W:0]   rq2_wptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rptr_gray;
    logic              empty;
    logic              almost_empty;
    logic              rd_ack;
    logic              underflow;

    modport master (
        output rd_en, rq2_wptr,
        input  rd_addr, rptr_gray, empty, almost_empty, rd_ack, underflow
    );

    modport slave (
        input  rd_en, rq2_wptr,
        output rd_addr, rptr_gray, empty, almost_empty, rd_ack, underflow
    );
endinterface

// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer and empty-flag generator for the async FIFO.
// Define FIFO_ALMOST_EMPTY_EN to build the occupancy-based almost_empty flag.
module fifo_rd_ptr_empty #(
    parameter int ADDR_W    = 4,
    parameter int AE_THRESH = 2
) (
    input logic                clk,
    input logic                rst,
    fifo_rd_ptr_empty_if.slave bus
);
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] rgray;
    logic [ADDR_W:0] rgray_next;
    logic            empty_q;
    logic            empty_next;
    logic            rd_ack_q;
    logic            underflow_q;
    logic            rd_inc;

    assign rd_inc     = bus.rd_en & ~empty_q;
    assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_inc};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    // Full-width compare including the wrap bit; uses this cycle's rq2_wptr.
    assign empty_next = (rgray_next == bus.rq2_wptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin        <= '0;
            rgray       <= '0;
            empty_q     <= 1'b1;
            rd_ack_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            rgray       <= rgray_next;
            empty_q     <= empty_next;
            rd_ack_q    <= rd_inc;
            underflow_q <= underflow_q | (bus.rd_en & empty_q);
        end
    end

    // Gray pointer leaves straight from a flop so the write-domain synchronizer sees no glitches.
    assign bus.rd_addr   = rbin[ADDR_W-1:0];
    assign bus.rptr_gray = rgray;
    assign bus.empty     = empty_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.underflow = underflow_q;

`ifdef FIFO_ALMOST_EMPTY_EN
    localparam logic [ADDR_W:0] AE_LIMIT = (ADDR_W + 1)'(AE_THRESH);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] level_next;
    logic            almost_empty_q;

    always_comb begin
        wbin         = '0;
        wbin[ADDR_W] = bus.rq2_wptr[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ bus.rq2_wptr[i];
        end
    end

    assign level_next = wbin - rbin_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= (level_next <= AE_LIMIT);
        end
    end

    assign bus.almost_empty = almost_empty_q;
`else
    assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for fifo_rd_ptr_empty: a count-based FIFO model predicts each
// cycle's outputs into a queue that a separate monitor pops and compares.
module tb_fifo_rd_ptr_empty;
    localparam int ADDR_W    = 4;
    localparam int AE_THRESH = 2;
`ifdef FIFO_ALMOST_EMPTY_EN
    localparam bit AE_ON = 1'b1;
`else
    localparam bit AE_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [4:0] gray;
        logic       empty;
        logic       ae;
        logic       ack;
        logic       uf;
    } exp_t;

    logic clk;
    logic rst;
    fifo_rd_ptr_empty_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_rd_ptr_empty #(.ADDR_W(ADDR_W), .AE_THRESH(AE_THRESH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: total reads ever accepted and the registered flags.
    int   m_rd    = 0;
    bit   m_empty = 1'b1;
    bit   m_uf    = 1'b0;
    int   wcnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("rd_addr", int'(bus.rd_addr), int'(e.addr));
        cmp("rptr_gray", int'(bus.rptr_gray), int'(e.gray));
        cmp("empty", int'(bus.empty), int'(e.empty));
        cmp("almost_empty", int'(bus.almost_empty), int'(e.ae));
        cmp("rd_ack", int'(bus.rd_ack), int'(e.ack));
        cmp("underflow", int'(bus.underflow), int'(e.uf));
    endtask

    // Drive one cycle of inputs and push what the FIFO should show after the next edge.
    task automatic applyStimulus(input bit r, input bit en, input int w);
        exp_t e;
        bit   acc;
        int   occ;
        @(posedge clk);
        #2;
        rst          = r;
        bus.rd_en    = en;
        bus.rq2_wptr = gray(w);
        if (r) begin
            m_rd    = 0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
            e.ack   = 1'b0;
            e.ae    = AE_ON;
        end else begin
            acc     = en && !m_empty;
            m_uf    = m_uf || (en && m_empty);
            m_rd    = m_rd + int'(acc);
            occ     = w - m_rd;
            m_empty = (occ == 0);
            e.ack   = acc;
            e.ae    = AE_ON && (occ <= AE_THRESH);
        end
        e.empty = m_empty;
        e.uf    = m_uf;
        e.addr  = 4'(m_rd % 16);
        e.gray  = gray(m_rd);
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int occ;
        rst          = 1'b1;
        bus.rd_en    = 1'b0;
        bus.rq2_wptr = '0;

        // Reset with a nonzero synchronized write pointer, then release.
        applyStimulus(1, 0, 6);
        applyStimulus(1, 0, 6);

        // Underflow: read attempt on an empty FIFO, flag must stick.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0);

        // Drain three entries with four read requests.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 3);
        repeat (4) applyStimulus(0, 1, 3);
        repeat (2) applyStimulus(0, 0, 3);

        // Walk the pointer to 31, then read across the wrap.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(0, 0, i + 1);
            applyStimulus(0, 1, i + 1);
        end
        applyStimulus(0, 0, 33);
        repeat (2) applyStimulus(0, 1, 33);
        applyStimulus(0, 0, 33);

        // Write pointer advances in the same cycle as a read.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 3);
        repeat (2) applyStimulus(0, 1, 3);
        applyStimulus(0, 1, 4);
        applyStimulus(0, 0, 4);

        // Almost-empty threshold crossing.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 4);
        repeat (3) applyStimulus(0, 1, 4);

        // Randomized traffic with occasional reset of both sides.
        applyStimulus(1, 0, 0);
        wcnt = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                wcnt = 0;
                applyStimulus(1, 0, 0);
            end else begin
                occ = wcnt - m_rd;
                if (occ < 15 && $urandom_range(0, 3) == 0) wcnt += 2;
                else if (occ < 16 && $urandom_range(0, 1) == 0) wcnt += 1;
                applyStimulus(0, 1'($urandom_range(0, 2) != 0), wcnt);
            end
        end

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
